// File: rtl/squeeze_sched.sv
// Squeeze-layer weight sequencer: walks (group, chunk) for one fire layer and
// streams 8-lane weight/bias address beats to the MAC array over valid/ready.
module squeeze_sched #(
  parameter int LANES = 8,
  parameter int CHPAR = 16,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          fire_in,
  input  logic                abort,
  output logic [2:0]          firesel,
  output logic [LANES*AW-1:0] addr_w,
  output logic [LANES*AW-1:0] addr_f,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic                first_chunk,
  output logic                last_chunk,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [AW-1:0] cin_of(input logic [2:0] f);
    case (f)
      3'd0:       cin_of = AW'(64);
      3'd1, 3'd2: cin_of = AW'(128);
      3'd3, 3'd4: cin_of = AW'(256);
      3'd5, 3'd6: cin_of = AW'(384);
      default:    cin_of = AW'(512);
    endcase
  endfunction

  function automatic logic [4:0] nch_m1_of(input logic [2:0] f);
    case (f)
      3'd0:       nch_m1_of = 5'd3;
      3'd1, 3'd2: nch_m1_of = 5'd7;
      3'd3, 3'd4: nch_m1_of = 5'd15;
      3'd5, 3'd6: nch_m1_of = 5'd23;
      default:    nch_m1_of = 5'd31;
    endcase
  endfunction

  function automatic logic [2:0] ngrp_m1_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd1: ngrp_m1_of = 3'd1;
      3'd2, 3'd3: ngrp_m1_of = 3'd3;
      3'd4, 3'd5: ngrp_m1_of = 3'd5;
      default:    ngrp_m1_of = 3'd7;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic [2:0]    fire_r;
  logic [4:0]    c_r;
  logic [2:0]    g_r;
  logic [AW-1:0] aw_r   [LANES];
  logic [AW-1:0] af_r   [LANES];
  logic [AW-1:0] init_w [LANES];
  logic [AW-1:0] cin_cur;
  logic [AW-1:0] grp_step;
  logic          run, accept, load, last_c, last_g;

  assign run      = (state == RUN);
  assign accept   = run && beat_ready && !abort;
  assign load     = (state == IDLE) && start && !abort;
  assign cin_cur  = cin_of(fire_r);
  assign last_c   = (c_r == nch_m1_of(fire_r));
  assign last_g   = (g_r == ngrp_m1_of(fire_r));
  // From the last chunk of row r to chunk 0 of row r+8: +8*Cin - (Cin-16)
  assign grp_step = (cin_cur << 3) - cin_cur + AW'(CHPAR);

  // Lane row bases k*Cin built as an adder chain from the requested layer
  always_comb begin : lane_init
    logic [AW-1:0] acc;
    acc = '0;
    for (int k = 0; k < LANES; k++) begin
      init_w[k] = acc;
      acc       = acc + cin_of(fire_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN: begin
        if (abort)                          state_nxt = IDLE;
        else if (accept && last_c && last_g) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_r <= '0;
      c_r    <= '0;
      g_r    <= '0;
      for (int k = 0; k < LANES; k++) begin
        aw_r[k] <= '0;
        af_r[k] <= '0;
      end
    end else if (load) begin
      fire_r <= fire_in;
      c_r    <= '0;
      g_r    <= '0;
      for (int k = 0; k < LANES; k++) begin
        aw_r[k] <= init_w[k];
        af_r[k] <= AW'(k);
      end
    end else if (accept) begin
      if (last_c) begin
        c_r <= '0;
        g_r <= g_r + 3'd1;
        for (int k = 0; k < LANES; k++) begin
          aw_r[k] <= aw_r[k] + grp_step;
          af_r[k] <= af_r[k] + AW'(LANES);
        end
      end else begin
        c_r <= c_r + 5'd1;
        for (int k = 0; k < LANES; k++) aw_r[k] <= aw_r[k] + AW'(CHPAR);
      end
    end
  end

  // Outputs decode from registered state only, so beat_ready never reaches them
  always_comb begin
    firesel     = (state != IDLE) ? fire_r : 3'd0;
    beat_valid  = run;
    busy        = run;
    done        = (state == DONE);
    first_chunk = run && (c_r == 5'd0);
    last_chunk  = run && last_c;
    addr_w      = '0;
    addr_f      = '0;
    for (int k = 0; k < LANES; k++) begin
      addr_w[k*AW +: AW] = run ? aw_r[k] : '0;
      addr_f[k*AW +: AW] = run ? af_r[k] : '0;
    end
  end

endmodule

// File: doc/squeeze_sched.md
Name: squeeze_sched

Overview:
- Sequencer that walks the squeeze (1x1 conv) weight/bias ROM for one fire layer and streams weight-read beats to the 8-filter x 16-channel MAC array.
- Each beat presents 8 weight base addresses (one per filter lane; the ROM returns 16 consecutive channel weights per lane) and 8 bias/filter indices, plus accumulator control flags.
- Sits between the top-level layer controller (start/done) and the squeeze weight ROM plus MAC array (valid/ready).

Parameters:
- LANES, 8, filter lanes served per beat; fixed at 8.
- CHPAR, 16, channels consumed per beat; fixed at 16.
- AW, 32, width of each weight and filter address.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a layer; sampled only in IDLE.
- fire_in  in  3  layer select (0..7), captured on accepted start.
- abort  in  1  synchronous abort; returns to IDLE without done.
- firesel  out  3  layer select driven to the ROM; held for the whole run.
- addr_w  out  LANES*AW  lane k weight base address, bits [k*AW +: AW].
- addr_f  out  LANES*AW  lane k filter/bias index, bits [k*AW +: AW].
- beat_valid  out  1  addresses and flags are valid this cycle.
- beat_ready  in  1  MAC array accepts the beat.
- first_chunk  out  1  beat is chunk 0 of its filter group (clear accumulators).
- last_chunk  out  1  beat is the final chunk of its group (add bias, write out).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last beat of the layer is accepted.

Behaviour:
- Layer geometry (fire 0..7): Cin = 64,128,128,256,256,384,384,512; Cout = 16,16,32,32,48,48,64,64. NCH = Cin/16 = 4,8,8,16,16,24,24,32; NGRP = Cout/8 = 2,2,4,4,6,6,8,8. Geometry comes from an internal constant lookup indexed by the captured fire value.
- Address rules for group g (0..NGRP-1) and chunk c (0..NCH-1), lane k: addr_f = 8g+k; addr_w = (8g+k)*Cin + 16c. Computed incrementally (adders only, no multipliers) and held in registers.
- Beat order: c is the inner loop and g the outer loop. A layer has NGRP*NCH beats.
- Flags: first_chunk = (c==0); last_chunk = (c==NCH-1).
- FSM states:
  - IDLE: all outputs 0. On start, capture fire_in into firesel, load g=0, c=0, go to RUN. beat_valid rises on the cycle after start.
  - RUN: busy=1, beat_valid=1. A beat is accepted when beat_valid && beat_ready; on acceptance c increments. When c wraps, c returns to 0 and g increments. Acceptance of beat (NGRP-1, NCH-1) moves the FSM to DONE.
  - DONE: done=1, beat_valid=0, busy=0 for exactly one cycle, then IDLE.
- Backpressure: while beat_ready=0, addr_w, addr_f, the flags and beat_valid hold stable. There is no combinational path from beat_ready to any output.
- A start pulse in RUN or DONE is ignored, and fire_in is not recaptured.
- abort in RUN or DONE forces IDLE on the next edge: no done pulse, outputs return to 0. abort takes priority over a same-cycle handshake and over start. abort in IDLE has no effect.
- start and abort asserted together in IDLE: abort wins and the FSM stays in IDLE.
- rst_n low at any time, including mid-run: immediately forces IDLE, firesel=0, all addresses, flags, beat_valid, busy and done = 0. The interrupted run is not resumed after reset release.
- Back-to-back runs: start is accepted in IDLE the cycle after done.
- Address arithmetic is unsigned, AW bits. The maximum address is 32752, so no overflow is possible.

Test Plan:
- Fire 0, beat_ready tied 1: start with fire_in=0 -> 8 beats on consecutive cycles. Beat 0: addr_w lane k = 64k, addr_f = k, first_chunk=1. Beat 3: lane 0 addr_w = 48, last_chunk=1. Beat 4: lane 0 addr_w = 512, addr_f = 8. done pulses one cycle after beat 7 is accepted; busy goes high the cycle after start and drops with done.
- Fire 7 full run: 256 beats. Final beat: lane 7 addr_w = 32752, addr_f = 63, last_chunk=1. firesel stays 7 throughout.
- Backpressure, fire 2: beat_ready toggles in a random pattern -> outputs frozen while ready=0; beat sequence identical to the ready=1 run; total accepted beats = 32.
- start pulsed mid-run with fire_in=5 -> ignored; firesel stays at the original value; beat count is unchanged.
- abort asserted on beat 10 of fire 4 -> next cycle in IDLE, beat_valid=0, no done. A following start with fire_in=1 runs 16 beats cleanly from addr_w lane 0 = 0.
- rst_n dropped asynchronously mid-run of fire 6 -> all outputs 0 without waiting for a clock edge. After release, the FSM idles until start.
